// File: rtl/id_operand_stage_pkg.sv
// Shared decode constants, ALU op codes and the ID/EX bundle.
// Imported by id_operand_stage, reg_file_32x32 and the ALU.
package id_operand_stage_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memrd;
    logic        memwr;
    logic [31:0] store;
    logic        illegal;
  } id_ex_t;

endpackage

// File: rtl/reg_file_32x32.sv
// 32x32 register file: 2 async read ports, 1 sync write port.
// Ports: clk, rst_n, i_we/i_waddr/i_wdata, i_ra1/i_ra2, o_rd1/o_rd2.
module reg_file_32x32
  import id_operand_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] r_mem [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++)
        r_mem[i] <= '0;
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : r_mem[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/id_operand_stage.sv
// Decode + operand fetch with forwarding; drives the ID/EX register.
// Ports: clk, rst_n, ins/ins_valid, stall, flush, wb_*, fwd_*, ex_*.
module id_operand_stage
  import id_operand_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ins,
  input  logic        ins_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        fwd_en,
  input  logic [4:0]  fwd_addr,
  input  logic [31:0] fwd_data,
  output logic        ex_valid,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [2:0]  ex_op,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memrd,
  output logic        ex_memwr,
  output logic [31:0] ex_store,
  output logic        ex_illegal
);

  logic [5:0]  w_opc;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rdf;
  logic [31:0] w_imm;
  logic [31:0] w_rf1;
  logic [31:0] w_rf2;
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [2:0]  w_op;
  logic [31:0] w_b;
  logic [4:0]  w_dst;
  logic        w_regwr;
  logic        w_memrd;
  logic        w_memwr;
  logic        w_ill;
  id_ex_t      w_d;
  id_ex_t      r_q;

  assign w_opc   = ins[31:26];
  assign w_rs    = ins[25:21];
  assign w_rt    = ins[20:16];
  assign w_rdf   = ins[15:11];
  assign w_funct = ins[5:0];
  assign w_imm   = {{16{ins[15]}}, ins[15:0]};

  reg_file_32x32 u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (wb_en),
    .i_waddr (wb_addr),
    .i_wdata (wb_data),
    .i_ra1   (w_rs),
    .i_ra2   (w_rt),
    .o_rd1   (w_rf1),
    .o_rd2   (w_rf2)
  );

  // EX/MEM is younger than WB, so it wins.
  always_comb begin
    w_rs_val = w_rf1;
    if (w_rs == 5'd0)
      w_rs_val = '0;
    else if (fwd_en && (fwd_addr == w_rs))
      w_rs_val = fwd_data;
    else if (wb_en && (wb_addr == w_rs))
      w_rs_val = wb_data;
  end

  always_comb begin
    w_rt_val = w_rf2;
    if (w_rt == 5'd0)
      w_rt_val = '0;
    else if (fwd_en && (fwd_addr == w_rt))
      w_rt_val = fwd_data;
    else if (wb_en && (wb_addr == w_rt))
      w_rt_val = wb_data;
  end

  always_comb begin
    w_op    = OP_ADD;
    w_b     = w_rt_val;
    w_dst   = 5'd0;
    w_regwr = 1'b0;
    w_memrd = 1'b0;
    w_memwr = 1'b0;
    w_ill   = 1'b0;
    unique case (1'b1)
      (w_opc == OPC_RTYPE): begin
        w_dst   = w_rdf;
        w_regwr = 1'b1;
        unique case (1'b1)
          (w_funct == F_ADD): w_op = OP_ADD;
          (w_funct == F_SUB): w_op = OP_SUB;
          (w_funct == F_AND): w_op = OP_AND;
          (w_funct == F_OR):  w_op = OP_OR;
          (w_funct == F_SLT): w_op = OP_SLT;
          default: begin
            w_ill   = 1'b1;
            w_regwr = 1'b0;
          end
        endcase
      end
      (w_opc == OPC_ADDI): begin
        w_b     = w_imm;
        w_dst   = w_rt;
        w_regwr = 1'b1;
      end
      (w_opc == OPC_LW): begin
        w_b     = w_imm;
        w_dst   = w_rt;
        w_regwr = 1'b1;
        w_memrd = 1'b1;
      end
      (w_opc == OPC_SW): begin
        w_b     = w_imm;
        w_memwr = 1'b1;
      end
      (w_opc == OPC_BEQ): begin
        w_op = OP_SUB;
      end
      default: begin
        w_ill = 1'b1;
      end
    endcase
    if (w_dst == 5'd0)
      w_regwr = 1'b0;
  end

  always_comb begin
    w_d          = '0;
    w_d.valid    = ins_valid;
    w_d.a        = w_rs_val;
    w_d.b        = w_b;
    w_d.op       = w_op;
    w_d.rd       = w_dst;
    w_d.store    = w_rt_val;
    w_d.regwrite = ins_valid & w_regwr;
    w_d.memrd    = ins_valid & w_memrd;
    w_d.memwr    = ins_valid & w_memwr;
    w_d.illegal  = ins_valid & w_ill;
  end

  // Flush only kills control; data fields simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (flush) begin
      r_q.valid    <= 1'b0;
      r_q.regwrite <= 1'b0;
      r_q.memrd    <= 1'b0;
      r_q.memwr    <= 1'b0;
      r_q.illegal  <= 1'b0;
    end else if (!stall) begin
      r_q <= w_d;
    end
  end

  assign ex_valid    = r_q.valid;
  assign ex_a        = r_q.a;
  assign ex_b        = r_q.b;
  assign ex_op       = r_q.op;
  assign ex_rd       = r_q.rd;
  assign ex_regwrite = r_q.regwrite;
  assign ex_memrd    = r_q.memrd;
  assign ex_memwr    = r_q.memwr;
  assign ex_store    = r_q.store;
  assign ex_illegal  = r_q.illegal;

endmodule
